// File: rtl/io_cfg_pkg.sv
// Shared state type and sizing helpers for the io_block configuration loader.
// Build option: IO_CFG_CHECKSUM_EN adds a trailing XOR checksum byte to every load.
`timescale 1ns/1ps
package io_cfg_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
`ifdef IO_CFG_CHECKSUM_EN
      ST_CHECK  = 3'd2,
      ST_ERR    = 3'd4,
`endif
      ST_COMMIT = 3'd3
   } state_t;

   function automatic int sel_per_in(input int extin);
      return $clog2(extin);
   endfunction

   function automatic int sel_per_out(input int ws, input int wd);
      return $clog2(ws + wd);
   endfunction

   function automatic int cfg_width(input int ws, input int wd, input int wg,
                                    input int extin, input int extout);
      return sel_per_in(extin) * (ws + wd + wg) + sel_per_out(ws, wd) * extout;
   endfunction

   function automatic int num_words(input int cfg_w);
      return (cfg_w + BYTE_W - 1) / BYTE_W;
   endfunction

endpackage

// File: rtl/io_cfg_shadow.sv
// Byte-addressed shadow of the configuration word; bits beyond CFG_W in the
// last byte lane are never stored.
`timescale 1ns/1ps
module io_cfg_shadow
   import io_cfg_pkg::*;
#(
   parameter int CFG_W  = 56,
   parameter int NWORDS = 7,
   parameter int IDX_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [BYTE_W-1:0] data,
   output logic [CFG_W-1:0]  q
);

   for (genvar b = 0; b < NWORDS; b++) begin : g_byte
      localparam int LO = b * BYTE_W;
      localparam int HI = ((LO + BYTE_W) > CFG_W) ? (CFG_W - 1) : (LO + BYTE_W - 1);

      logic [HI-LO:0] byte_r;

      // Lane b captures the incoming byte only when the loader points at it.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            byte_r <= '0;
         end else if (we && (idx == IDX_W'(b))) begin
            byte_r <= data[HI-LO:0];
         end
      end

      assign q[HI:LO] = byte_r;
   end

endmodule

// File: rtl/io_config_loader.sv
// Streams a byte-serial bitstream into a shadow register and commits it to c
// atomically. Build option: IO_CFG_CHECKSUM_EN (trailer byte = XOR of data bytes).
`timescale 1ns/1ps
module io_config_loader
   import io_cfg_pkg::*;
#(
   parameter  int WS     = 7,
   parameter  int WD     = 6,
   parameter  int WG     = 3,
   parameter  int EXTIN  = 5,
   parameter  int EXTOUT = 2,
   localparam int CFG_W  = cfg_width(WS, WD, WG, EXTIN, EXTOUT),
   localparam int NWORDS = num_words(CFG_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [BYTE_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [CFG_W-1:0]  c,
   output logic              cfg_valid,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   state_t           state_r;
   logic [IDX_W-1:0] cnt_r;
   logic [CFG_W-1:0] c_r;
   logic [CFG_W-1:0] shadow_s;
   logic             din_ready_r;
   logic             cfg_valid_r;
   logic             busy_r;
   logic             done_r;
   logic             accept_s;
   logic             last_s;
   logic             shadow_we_s;
`ifdef IO_CFG_CHECKSUM_EN
   logic [BYTE_W-1:0] csum_r;
   logic              err_r;
`endif

   assign accept_s    = din_valid && din_ready_r;
   assign last_s      = (cnt_r == IDX_W'(NWORDS - 1));
   assign shadow_we_s = accept_s && (state_r == ST_LOAD);

   io_cfg_shadow #(
      .CFG_W  (CFG_W),
      .NWORDS (NWORDS),
      .IDX_W  (IDX_W)
   ) u_shadow (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (shadow_we_s),
      .idx   (cnt_r),
      .data  (din),
      .q     (shadow_s)
   );

   // Load sequencer; every output is registered and c moves only in COMMIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         c_r         <= '0;
         din_ready_r <= 1'b0;
         cfg_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
`ifdef IO_CFG_CHECKSUM_EN
         csum_r      <= '0;
         err_r       <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r     <= ST_LOAD;
                  cnt_r       <= '0;
                  din_ready_r <= 1'b1;
                  busy_r      <= 1'b1;
`ifdef IO_CFG_CHECKSUM_EN
                  csum_r      <= '0;
                  err_r       <= 1'b0;
`endif
               end
            end
            ST_LOAD: begin
               if (accept_s) begin
`ifdef IO_CFG_CHECKSUM_EN
                  csum_r <= csum_r ^ din;
`endif
                  if (last_s) begin
`ifdef IO_CFG_CHECKSUM_EN
                     state_r     <= ST_CHECK;
`else
                     state_r     <= ST_COMMIT;
                     din_ready_r <= 1'b0;
`endif
                  end else begin
                     cnt_r <= cnt_r + IDX_W'(1);
                  end
               end
            end
`ifdef IO_CFG_CHECKSUM_EN
            ST_CHECK: begin
               if (accept_s) begin
                  din_ready_r <= 1'b0;
                  state_r     <= (din == csum_r) ? ST_COMMIT : ST_ERR;
               end
            end
            // A bad trailer leaves c and cfg_valid untouched.
            ST_ERR: begin
               err_r   <= 1'b1;
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
`endif
            ST_COMMIT: begin
               c_r         <= shadow_s;
               cfg_valid_r <= 1'b1;
               done_r      <= 1'b1;
               state_r     <= ST_IDLE;
               busy_r      <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               din_ready_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign c         = c_r;
   assign cfg_valid = cfg_valid_r;
   assign din_ready = din_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
`ifdef IO_CFG_CHECKSUM_EN
   assign err       = err_r;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_io_config_loader.sv
// Scoreboard bench for io_config_loader: expected words are queued per load
// and popped by a monitor on every done pulse.
`timescale 1ns/1ps
module tb_io_config_loader;

   localparam int CFG_W = 56;
   localparam int NW    = 7;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start;
   logic [7:0]       din;
   logic             din_valid;
   logic             din_ready;
   logic [CFG_W-1:0] c;
   logic             cfg_valid;
   logic             busy;
   logic             done;
   logic             err;

   int               n_checks = 0;
   int               n_pass = 0;
   logic [CFG_W-1:0] exp_q[$];
   logic [CFG_W-1:0] model_c;
   logic [7:0]       ld_bytes[0:NW-1];
   logic [7:0]       ld_trl;

   always #5 clk = ~clk;

   io_config_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .c         (c),
      .cfg_valid (cfg_valid),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Configuration word = bytes laid end to end, byte 0 in the low bits.
   function automatic logic [CFG_W-1:0] model_cfg();
      logic [NW*8-1:0] w;
      w = '0;
      for (int n = 0; n < NW; n++) w = w | ((NW*8)'(ld_bytes[n]) << (8 * n));
      return w[CFG_W-1:0];
   endfunction

   function automatic logic [7:0] model_sum();
      logic [7:0] s;
      s = 8'h00;
      for (int n = 0; n < NW; n++) s = s ^ ld_bytes[n];
      return s;
   endfunction

   initial begin : monitor
      logic             prev_done;
      logic [CFG_W-1:0] e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got done=1 expected no commit");
            end else begin
               e = exp_q.pop_front();
               check("commit_c", 64'(c), 64'(e));
               check("commit_cfg_valid", 64'(cfg_valid), 64'd1);
            end
            if (prev_done) begin
               n_checks++;
               $display("FAIL done_pulse_width: got 2+ cycles expected 1");
            end
         end
         prev_done = done;
      end
   end

   // mode 0: back-to-back, 1: alternate bubbles, 2: random bubbles and stray start pulses
   task automatic run_load(input int mode);
      int               total, acc, iter, bubbles, cyc;
      bit               v, exp_ok;
      logic [CFG_W-1:0] exp_c;
`ifdef IO_CFG_CHECKSUM_EN
      total  = NW + 1;
      exp_ok = (ld_trl == model_sum());
`else
      total  = NW;
      exp_ok = 1'b1;
`endif
      exp_c = model_cfg();
      if (exp_ok) exp_q.push_back(exp_c);
      @(posedge clk); #1;
      start = 1'b1;
      din_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      acc = 0; iter = 0; bubbles = 0;
      while (acc < total && iter < 2000) begin
         case (mode)
            0: v = 1'b1;
            1: v = ((iter % 2) == 0);
            default: v = ($urandom_range(3) != 0);
         endcase
         din_valid = v;
         din = (acc < NW) ? ld_bytes[acc] : ld_trl;
         if (!v) begin
            din = 8'($urandom);
            bubbles++;
         end
         start = (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
         @(negedge clk);
         if (iter == 0) begin
            check("busy_in_load", 64'(busy), 64'd1);
            check("err_cleared_on_start", 64'(err), 64'd0);
         end
         check("c_held_during_load", 64'(c), 64'(model_c));
         if (v && din_ready) acc++;
         @(posedge clk); #1;
         iter++;
      end
      din_valid = 1'b0;
      start = 1'b0;
      check("bytes_accepted", 64'(acc), 64'(total));
      cyc = 0;
      while (!done && !err && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("commit_latency", 64'(cyc), 64'd1);
      check("total_cycles", 64'(iter + cyc), 64'(total + bubbles + 1));
      if (exp_ok) begin
         model_c = exp_c;
      end else begin
         check("err_flag", 64'(err), 64'd1);
         check("c_kept_on_err", 64'(c), 64'(model_c));
         check("no_done_on_err", 64'(done), 64'd0);
      end
   endtask

   initial begin
      start = 1'b0; din_valid = 1'b0; din = 8'h00;
      model_c = '0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_c", 64'(c), 64'd0);
      check("rst_cfg_valid", 64'(cfg_valid), 64'd0);
      check("rst_din_ready", 64'(din_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // din_valid while idle must not be taken
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         din_valid = 1'b1; din = 8'hEE;
         @(negedge clk);
         check("idle_din_ready", 64'(din_ready), 64'd0);
         check("idle_busy", 64'(busy), 64'd0);
      end
      din_valid = 1'b0;

      for (int n = 0; n < NW; n++) ld_bytes[n] = 8'(n + 1);
      ld_trl = 8'h00;
      run_load(0);
      check("directed_c", 64'(c), 64'h0007060504030201);

      // Mid-cycle asynchronous reset
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      check("async_rst_c", 64'(c), 64'd0);
      check("async_rst_cfg_valid", 64'(cfg_valid), 64'd0);
      check("async_rst_din_ready", 64'(din_ready), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      model_c = '0;
      @(negedge clk); rst_n = 1'b1;

      run_load(1);
      check("bubble_c", 64'(c), 64'h0007060504030201);
      run_load(2);
      check("stray_start_c", 64'(c), 64'h0007060504030201);

      // Reset after three accepted bytes discards the partial load
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1; din = 8'h3C;
         @(posedge clk); #1;
      end
      din_valid = 1'b0;
      #2 rst_n = 1'b0; #1;
      check("partial_rst_c", 64'(c), 64'd0);
      check("partial_rst_busy", 64'(busy), 64'd0);
      check("partial_rst_din_ready", 64'(din_ready), 64'd0);
      model_c = '0;
      @(negedge clk); rst_n = 1'b1;
      for (int n = 0; n < NW; n++) ld_bytes[n] = 8'hA5;
      ld_trl = 8'hA5;
      run_load(0);
      check("a5_c", 64'(c), 64'h00A5A5A5A5A5A5A5);

`ifdef IO_CFG_CHECKSUM_EN
      for (int n = 0; n < NW; n++) ld_bytes[n] = 8'(n + 1);
      ld_trl = 8'h00;
      run_load(0);
      for (int n = 0; n < NW; n++) ld_bytes[n] = 8'hFF;
      ld_trl = 8'h5A;
      run_load(0);
      check("bad_trailer_c", 64'(c), 64'h0007060504030201);
      check("bad_trailer_err", 64'(err), 64'd1);
`endif

      for (int k = 0; k < 20; k++) begin
         for (int n = 0; n < NW; n++) ld_bytes[n] = 8'($urandom);
         ld_trl = ($urandom_range(3) == 0) ? 8'($urandom) : model_sum();
         run_load(2);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/io_config_loader.md
IO_CONFIG_LOADER -- requirements
Module: io_config_loader

Interface
REQ-001 Parameter WS, default 7: single-track count of the target io_block.
REQ-002 Parameter WD, default 6: double-track count.
REQ-003 Parameter WG, default 3: global-track count.
REQ-004 Parameter EXTIN, default 5: external input pin count.
REQ-005 Parameter EXTOUT, default 2: external output pin count.
REQ-006 Derived values SHALL be: SEL_PER_IN=$clog2(EXTIN), SEL_PER_OUT=$clog2(WS+WD), CFG_W=SEL_PER_IN*(WS+WD+WG)+SEL_PER_OUT*EXTOUT, NWORDS=ceil(CFG_W/8). Defaults give CFG_W=56 and NWORDS=7.
REQ-007 clk  input  1  sole clock; all state changes on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  single-cycle request to begin a load.
REQ-010 din  input  8  bitstream byte.
REQ-011 din_valid  input  1  din holds a byte.
REQ-012 din_ready  output  1  loader accepts din this cycle.
REQ-013 c  output  CFG_W  configuration word driving io_block c; bit 0 = first select bit of single_out[0].
REQ-014 cfg_valid  output  1  c holds a committed configuration.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse on commit.
REQ-017 err  output  1  sticky error flag.

Function
REQ-018 States SHALL be IDLE, LOAD, CHECK (macro only), COMMIT and ERR.
REQ-019 IDLE with start=1 SHALL go to LOAD next cycle and clear the word counter and err.
REQ-020 A byte SHALL be accepted only when din_valid and din_ready are both 1; din_ready SHALL be 1 only in LOAD (and CHECK).
REQ-021 Accepted byte n (0-based) SHALL be written to shadow[8n+7:8n]; bits at or above CFG_W in the last byte SHALL be discarded.
REQ-022 din_valid gaps SHALL stall the load with no state loss; there is no timeout.
REQ-023 After the NWORDS-th byte is accepted, the FSM SHALL go to COMMIT, or to CHECK when the checksum feature is compiled in.
REQ-024 COMMIT SHALL last one cycle: c <= shadow, cfg_valid <= 1, done = 1, then return to IDLE.
REQ-025 c SHALL NOT change outside COMMIT, so the io_block never sees a partial configuration.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 din_valid in IDLE SHALL be ignored; din_ready stays 0.
REQ-028 From load start to done, latency SHALL be NWORDS accepted bytes plus 1 cycle, or plus the checksum byte and 1 cycle with the macro.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, c=0, shadow=0, counter=0, cfg_valid=0, done=0, err=0 and din_ready=0.
REQ-030 Reset during LOAD SHALL discard the partial load; the next start performs a clean full load.

Configuration
REQ-031 The feature SHALL be controlled by macro IO_CFG_CHECKSUM_EN.
REQ-032 With the macro defined:
- CHECK accepts one trailer byte.
- If the trailer equals the XOR of all NWORDS data bytes, the FSM goes to COMMIT.
- Otherwise it goes to ERR for one cycle: err=1 (sticky until the next start), c and cfg_valid unchanged, then IDLE.
REQ-033 Without the macro, CHECK and ERR SHALL be absent and err SHALL be tied to 0.

Structure
REQ-034 Package io_cfg_pkg SHALL hold:
- the state enum;
- functions computing SEL_PER_IN, SEL_PER_OUT, CFG_W and NWORDS;
- the byte width constant (8).
REQ-035 The byte-indexed shadow register SHALL be sub-module io_cfg_shadow (write-enable, byte index, data in; full-width out). The FSM, counter and checksum SHALL stay in io_config_loader.

Verification
REQ-036 Reset: assert rst_n=0 mid-cycle -> c=0, cfg_valid=0, din_ready=0, busy=0 immediately.
REQ-037 Load: start, then bytes 0x01..0x07 back-to-back -> c=56'h07060504030201, cfg_valid=1, a single done pulse 1 cycle after the 7th accept, and c held at its old value throughout the load.
REQ-038 Same bytes with din_valid low on alternate cycles -> identical c, with done delayed by the number of bubbles.
REQ-039 start pulsed during LOAD, and din_valid pulsed in IDLE -> no restart and no byte accepted; the final c matches REQ-037.
REQ-040 Macro: bytes 0x01..0x07 plus trailer 0x00 -> commit. Then load 0xFF x7 with trailer 0x5A -> err=1, c stays 56'h07060504030201, done never pulses.
REQ-041 Reset after 3 accepted bytes, then a full load of 0xA5 x7 -> c=56'hA5A5A5A5A5A5A5. Cross-check by driving io_block with c and confirming its routing matches the decoded selects.
